// File: rtl/ysyx_23060061_axi4_sram_pkg.sv
// Shared AXI4 codes, FSM states and burst helpers
// for the ysyx_23060061 AXI4 SRAM responder.
package ysyx_23060061_axi4_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_e;

  // WRAP, reserved bursts and beats wider than the bus are refused
  function automatic logic bad_burst(
    input logic [1:0] burst,
    input logic [2:0] size
  );
    return ((burst != BURST_FIXED) && (burst != BURST_INCR))
      || (size > 3'd3);
  endfunction

  // INCR steps by the beat size, FIXED holds; wraps modulo 2^32
  function automatic logic [31:0] next_addr(
    input logic [31:0] a,
    input logic [1:0]  burst,
    input logic [2:0]  size
  );
    return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
  endfunction

endpackage

// File: rtl/ysyx_23060061_axi4_sram_array.sv
// 64-bit word storage with byte-strobe write
// and combinational read; contents never reset.
module ysyx_23060061_axi4_sram_array
  import ysyx_23060061_axi4_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [63:0]           wdata,
  input  logic [7:0]            wstrb,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [63:0]           rdata
);

  logic [63:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  // byte-lane write of the addressed word
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // read shows the pre-edge value on a same-cycle write
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ysyx_23060061_axi4_sram.sv
// AXI4 SRAM responder: independent write and read
// FSMs, one outstanding transaction per direction.
module ysyx_23060061_axi4_sram
  import ysyx_23060061_axi4_sram_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          RD_LAT     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam logic [32:0] SPAN = 33'd8 << DEPTH_LOG2;

  function automatic logic in_range(input logic [31:0] a);
    return {1'b0, a - BASE} < SPAN;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_of(
    input logic [31:0] a
  );
    return DEPTH_LOG2'((a - BASE) >> 3);
  endfunction

  w_state_e    w_state_q, w_state_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [3:0]  aw_id_q, aw_id_d;
  logic [7:0]  aw_len_q, aw_len_d;
  logic [2:0]  aw_size_q, aw_size_d;
  logic [1:0]  aw_burst_q, aw_burst_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic        w_dec_q, w_dec_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        w_hit, mem_we;

  r_state_e    r_state_q, r_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [7:0]  ar_len_q, ar_len_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [1:0]  ar_burst_q, ar_burst_d;
  logic [7:0]  r_beat_q, r_beat_d;
  logic [3:0]  r_lat_q, r_lat_d;
  logic [63:0] arr_rdata;
  logic        r_bad, r_hit;

  // state and latched transaction fields
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_dec_q    <= 1'b0;
      bresp_q    <= RESP_OKAY;
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
      r_lat_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_dec_q    <= w_dec_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_id_q    <= ar_id_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_beat_q   <= r_beat_d;
      r_lat_q    <= r_lat_d;
    end
  end

  // write FSM next state, beat bookkeeping, response code
  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_dec_d    = w_dec_q;
    bresp_d    = bresp_q;
    w_hit      = in_range(aw_addr_q);
    mem_we     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          aw_addr_d  = awaddr;
          aw_id_d    = awid;
          aw_len_d   = awlen;
          aw_size_d  = awsize;
          aw_burst_d = awburst;
          w_cnt_d    = '0;
          w_dec_d    = 1'b0;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we    = w_hit && !bad_burst(aw_burst_q, aw_size_q);
          aw_addr_d = next_addr(aw_addr_q, aw_burst_q, aw_size_q);
          w_cnt_d   = w_cnt_q + 8'd1;
          w_dec_d   = w_dec_q | !w_hit;
          if (wlast || (w_cnt_q == aw_len_q)) begin
            w_state_d = W_RESP;
            if (bad_burst(aw_burst_q, aw_size_q)
                || (wlast != (w_cnt_q == aw_len_q))) begin
              bresp_d = RESP_SLVERR;
            end else if (w_dec_d) begin
              bresp_d = RESP_DECERR;
            end else begin
              bresp_d = RESP_OKAY;
            end
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // write channel outputs
  always_comb begin
    awready = (w_state_q == W_IDLE);
    wready  = (w_state_q == W_DATA);
    bvalid  = (w_state_q == W_RESP);
    bresp   = bvalid ? bresp_q : RESP_OKAY;
    bid     = bvalid ? aw_id_q : '0;
  end

  // read FSM next state, latency countdown, beat walk
  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_beat_d   = r_beat_q;
    r_lat_d    = r_lat_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          ar_addr_d  = araddr;
          ar_id_d    = arid;
          ar_len_d   = arlen;
          ar_size_d  = arsize;
          ar_burst_d = arburst;
          r_beat_d   = '0;
          r_lat_d    = 4'(RD_LAT);
          r_state_d  = R_WAIT;
        end
      end
      R_WAIT: begin
        r_lat_d = r_lat_q - 4'd1;
        if (r_lat_q <= 4'd1) begin
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_beat_q == ar_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            ar_addr_d = next_addr(ar_addr_q, ar_burst_q, ar_size_q);
            r_beat_d  = r_beat_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // read channel outputs
  always_comb begin
    r_bad   = bad_burst(ar_burst_q, ar_size_q);
    r_hit   = in_range(ar_addr_q);
    arready = (r_state_q == R_IDLE);
    rvalid  = (r_state_q == R_DATA);
    rlast   = rvalid && (r_beat_q == ar_len_q);
    rid     = rvalid ? ar_id_q : '0;
    rdata   = (rvalid && !r_bad && r_hit) ? arr_rdata : '0;
    rresp   = RESP_OKAY;
    if (rvalid) begin
      if (r_bad) begin
        rresp = RESP_SLVERR;
      end else if (!r_hit) begin
        rresp = RESP_DECERR;
      end
    end
  end

  ysyx_23060061_axi4_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (word_of(aw_addr_q)),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (word_of(ar_addr_q)),
    .rdata (arr_rdata)
  );

endmodule
